// File: rtl/vram_responder_pkg.sv
// Shared definitions for the SNES VRAM responder: level-shifter direction codes,
// FSM state encoding, trace op codes and the packed layout of the synchronised bus word.
package vram_responder_pkg;

    localparam logic LVL_DIR_INPUT  = 1'b0;
    localparam logic LVL_DIR_OUTPUT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_FETCH = 2'd1,
        ST_RD_DRIVE = 2'd2,
        ST_WR_HOLD  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        TR_OP_NONE = 2'b00,
        TR_OP_READ = 2'b01,
        TR_OP_WR_A = 2'b10,
        TR_OP_WR_B = 2'b11
    } trace_op_t;

    // Bit positions of each pin group inside the synchroniser word.
    localparam int SB_RD      = 0;
    localparam int SB_AWR     = 1;
    localparam int SB_BWR     = 2;
    localparam int SB_VA14    = 3;
    localparam int SB_VAA     = 4;
    localparam int SB_VAB     = 18;
    localparam int SB_VDA     = 32;
    localparam int SB_VDB     = 40;
    localparam int BUS_SYNC_W = 48;

    // Strobes idle high so nothing looks like a fall right after reset.
    localparam logic [BUS_SYNC_W-1:0] SYNC_RST = 48'h0000_0000_0007;

    function automatic logic [23:0] trace_word(input trace_op_t op, input logic va14,
                                               input logic [12:0] idx, input logic [7:0] data);
        return {op, va14, idx, data};
    endfunction

endpackage

// File: rtl/vram_responder_bank.sv
// One emulated VRAM chip: single-port block RAM shared between bus and host,
// write-data capture register and the registered pin-side read data.
module vram_responder_bank
    import vram_responder_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_bus_sel,
    input  logic                 i_bus_we,
    input  logic [ADDR_BITS-1:0] i_bus_addr,
    input  logic                 i_host_we,
    input  logic                 i_host_re,
    input  logic [ADDR_BITS-1:0] i_host_addr,
    input  logic [7:0]           i_host_wdata,
    input  logic                 i_cap_en,
    input  logic [7:0]           i_cap_data,
    input  logic                 i_drive_load,
    input  logic                 i_drive_clr,
    output logic [7:0]           o_rd_data,
    output logic [7:0]           o_cap_data,
    output logic [7:0]           o_vd
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [7:0]           r_mem [DEPTH];
    logic [7:0]           r_rd_data;
    logic [7:0]           r_cap;
    logic [7:0]           r_vd;
    logic                 w_we;
    logic                 w_re;
    logic [ADDR_BITS-1:0] w_addr;
    logic [7:0]           w_wdata;

    // The bus always wins the port; the top only grants the host when the bus is quiet.
    assign w_we    = i_bus_sel ? i_bus_we : i_host_we;
    assign w_re    = i_bus_sel ? ~i_bus_we : i_host_re;
    assign w_addr  = i_bus_sel ? i_bus_addr : i_host_addr;
    assign w_wdata = i_bus_sel ? r_cap : i_host_wdata;

    always_ff @(posedge clock) begin
        if (w_we) begin
            r_mem[w_addr] <= w_wdata;
        end
        if (w_re) begin
            r_rd_data <= r_mem[w_addr];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cap <= 8'h00;
            r_vd  <= 8'h00;
        end else begin
            if (i_cap_en) begin
                r_cap <= i_cap_data;
            end
            if (i_drive_clr) begin
                r_vd <= 8'h00;
            end else if (i_drive_load) begin
                r_vd <= r_rd_data;
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_cap_data = r_cap;
    assign o_vd       = r_vd;

endmodule

// File: rtl/vram_responder.sv
// SNES VRAM bus responder (banks A and B) with a host preload/inspect port.
// Optional trace outputs are compiled in with VRAM_RESPONDER_TRACE_EN.
module vram_responder
    import vram_responder_pkg::*;
#(
    parameter int ADDR_BITS   = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 vrd_n,
    input  logic                 vawr_n,
    input  logic                 vbwr_n,
    input  logic                 va14,
    input  logic [13:0]          vaa,
    input  logic [13:0]          vab,
    input  logic [7:0]           vda_i,
    input  logic [7:0]           vdb_i,
    output logic [7:0]           vda_o,
    output logic [7:0]           vdb_o,
    output logic                 vd_dir_o,
    input  logic                 host_valid,
    output logic                 host_ready,
    input  logic                 host_we,
    input  logic                 host_bank,
    input  logic [ADDR_BITS-1:0] host_addr,
    input  logic [7:0]           host_wdata,
    output logic [7:0]           host_rdata,
    output logic                 host_rvalid,
    output logic                 error_conflict_o
`ifdef VRAM_RESPONDER_TRACE_EN
    ,
    output logic [23:0]          trace_data,
    output logic                 trace_valid
`endif
);

    logic [SYNC_STAGES-1:0][BUS_SYNC_W-1:0] r_sync;
    logic [BUS_SYNC_W-1:0]       w_pins;
    logic [BUS_SYNC_W-1:0]       w_sync;
    logic [2:0]                  w_pre_strb;
    logic                        w_rd_s;
    logic [1:0]                  w_wr_s;
    logic                        w_va14_s;
    logic [1:0][13:0]            w_va_s;
    logic [1:0][7:0]             w_vd_s;
    logic [1:0][ADDR_BITS-1:0]   w_idx;
    logic [1:0][ADDR_BITS-1:0]   w_bus_addr;
    logic [1:0][7:0]             w_rd_data;
    logic [1:0][7:0]             w_cap;
    logic [1:0][7:0]             w_vd_out;
    logic [1:0]                  w_bus_we;
    logic [1:0]                  w_cap_en;
    logic [1:0]                  w_host_we;
    logic [1:0]                  w_host_re;
    logic [1:0]                  w_fall_wr;
    logic                        w_fall_rd;
    logic                        w_all_high;
    logic                        w_conflict;
    logic                        w_bus_rd;
    logic                        w_wr_start;
    logic                        w_commit;
    logic                        w_host_acc;
    logic                        w_drive_load;
    logic                        w_drive_clr;
    state_t                      w_next_state;
    logic                        w_next_block;

    state_t                      r_state;
    logic                        r_block;
    logic [2:0]                  r_strb_d;
    logic [1:0]                  r_en;
    logic [1:0][ADDR_BITS-1:0]   r_addr;
    logic                        r_va14;
    logic                        r_vd_dir;
    logic                        r_host_ready;
    logic                        r_host_rvalid;
    logic                        r_host_bank;
    logic                        r_err;

    assign w_pins = {vdb_i, vda_i, vab, vaa, va14, vbwr_n, vawr_n, vrd_n};

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sync <= {SYNC_STAGES{SYNC_RST}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_pins};
        end
    end

    assign w_sync     = r_sync[SYNC_STAGES-1];
    // Strobes one stage early: what the synced strobes will be next cycle.
    assign w_pre_strb = r_sync[SYNC_STAGES-2][SB_BWR:SB_RD];
    assign w_rd_s     = w_sync[SB_RD];
    assign w_wr_s     = {w_sync[SB_BWR], w_sync[SB_AWR]};
    assign w_va14_s   = w_sync[SB_VA14];
    assign w_va_s[0]  = w_sync[SB_VAA +: 14];
    assign w_va_s[1]  = w_sync[SB_VAB +: 14];
    assign w_vd_s[0]  = w_sync[SB_VDA +: 8];
    assign w_vd_s[1]  = w_sync[SB_VDB +: 8];

    assign w_fall_rd  = r_strb_d[0] & ~w_rd_s;
    assign w_fall_wr  = r_strb_d[2:1] & ~w_wr_s;
    assign w_all_high = w_rd_s & (&w_wr_s);
    assign w_conflict = ~w_rd_s & ~(&w_wr_s);

    always_comb begin
        w_next_state = r_state;
        w_next_block = r_block & ~w_all_high;
        if (w_conflict) begin
            w_next_state = ST_IDLE;
            w_next_block = 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (!r_block) begin
                        if (w_fall_rd) begin
                            w_next_state = ST_RD_FETCH;
                        end else if (|w_fall_wr) begin
                            w_next_state = ST_WR_HOLD;
                        end
                    end
                end
                ST_RD_FETCH: w_next_state = ST_RD_DRIVE;
                ST_RD_DRIVE: if (w_rd_s) w_next_state = ST_IDLE;
                ST_WR_HOLD:  if (&w_wr_s) w_next_state = ST_IDLE;
                default:     w_next_state = ST_IDLE;
            endcase
        end
    end

    assign w_bus_rd     = (r_state == ST_IDLE) && (w_next_state == ST_RD_FETCH);
    assign w_wr_start   = (r_state == ST_IDLE) && (w_next_state == ST_WR_HOLD);
    assign w_commit     = (r_state == ST_WR_HOLD) && (w_next_state == ST_IDLE) && !w_conflict;
    assign w_host_acc   = host_valid && r_host_ready;
    assign w_drive_load = (r_state == ST_RD_FETCH) && (w_next_state == ST_RD_DRIVE);
    assign w_drive_clr  = (w_next_state != ST_RD_DRIVE);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            // Bus index aliases onto the low ADDR_BITS of {va14, vaX}.
            assign w_idx[gi]      = ADDR_BITS'({w_va14_s, w_va_s[gi]});
            assign w_bus_addr[gi] = (r_state == ST_WR_HOLD) ? r_addr[gi] : w_idx[gi];
            assign w_bus_we[gi]   = w_commit && r_en[gi] && reset;
            assign w_cap_en[gi]   = (w_wr_start || (r_state == ST_WR_HOLD)) && !w_wr_s[gi] && !w_conflict;
            assign w_host_we[gi]  = w_host_acc && host_we && (host_bank == 1'(gi));
            assign w_host_re[gi]  = w_host_acc && !host_we && (host_bank == 1'(gi));

            vram_responder_bank #(
                .ADDR_BITS (ADDR_BITS)
            ) u_bank (
                .clock        (clock),
                .reset        (reset),
                .i_bus_sel    (w_bus_rd | w_bus_we[gi]),
                .i_bus_we     (w_bus_we[gi]),
                .i_bus_addr   (w_bus_addr[gi]),
                .i_host_we    (w_host_we[gi]),
                .i_host_re    (w_host_re[gi]),
                .i_host_addr  (host_addr),
                .i_host_wdata (host_wdata),
                .i_cap_en     (w_cap_en[gi]),
                .i_cap_data   (w_vd_s[gi]),
                .i_drive_load (w_drive_load),
                .i_drive_clr  (w_drive_clr),
                .o_rd_data    (w_rd_data[gi]),
                .o_cap_data   (w_cap[gi]),
                .o_vd         (w_vd_out[gi])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_block       <= 1'b0;
            r_strb_d      <= 3'b111;
            r_en          <= 2'b00;
            r_addr        <= '0;
            r_va14        <= 1'b0;
            r_vd_dir      <= LVL_DIR_INPUT;
            r_host_ready  <= 1'b0;
            r_host_rvalid <= 1'b0;
            r_host_bank   <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_block       <= w_next_block;
            r_strb_d      <= {w_wr_s, w_rd_s};
            r_vd_dir      <= (w_next_state == ST_RD_DRIVE) ? LVL_DIR_OUTPUT : LVL_DIR_INPUT;
            r_host_ready  <= (w_next_state == ST_IDLE) && !w_next_block && (&w_pre_strb);
            r_host_rvalid <= w_host_acc && !host_we;
            if (w_host_acc) begin
                r_host_bank <= host_bank;
            end
            if (w_conflict) begin
                r_err <= 1'b1;
            end
            if (w_bus_rd || w_wr_start) begin
                r_addr <= w_idx;
                r_va14 <= w_va14_s;
                r_en   <= w_wr_start ? w_fall_wr : 2'b00;
            end else if (r_state == ST_WR_HOLD) begin
                // A strobe that follows the first one late still joins this write.
                for (int b = 0; b < 2; b++) begin
                    if (w_fall_wr[b]) begin
                        r_en[b]   <= 1'b1;
                        r_addr[b] <= w_idx[b];
                    end
                end
            end
        end
    end

    assign vda_o            = w_vd_out[0];
    assign vdb_o            = w_vd_out[1];
    assign vd_dir_o         = r_vd_dir;
    assign host_ready       = r_host_ready;
    assign host_rvalid      = r_host_rvalid;
    assign host_rdata       = r_host_rvalid ? w_rd_data[r_host_bank] : 8'h00;
    assign error_conflict_o = r_err;

`ifdef VRAM_RESPONDER_TRACE_EN
    logic [23:0] r_trace_data;
    logic        r_trace_valid;
    logic        r_tr_pend_b;

    // A dual-bank commit reports A first and B on the following cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_trace_data  <= 24'h000000;
            r_trace_valid <= 1'b0;
            r_tr_pend_b   <= 1'b0;
        end else begin
            r_trace_valid <= 1'b0;
            r_tr_pend_b   <= 1'b0;
            if (w_drive_load) begin
                r_trace_valid <= 1'b1;
                r_trace_data  <= trace_word(TR_OP_READ, r_va14, 13'(r_addr[0]), w_rd_data[0]);
            end else if (w_bus_we[0]) begin
                r_trace_valid <= 1'b1;
                r_trace_data  <= trace_word(TR_OP_WR_A, r_va14, 13'(r_addr[0]), w_cap[0]);
                r_tr_pend_b   <= w_bus_we[1];
            end else if (w_bus_we[1] || r_tr_pend_b) begin
                r_trace_valid <= 1'b1;
                r_trace_data  <= trace_word(TR_OP_WR_B, r_va14, 13'(r_addr[1]), w_cap[1]);
            end
        end
    end

    assign trace_data  = r_trace_data;
    assign trace_valid = r_trace_valid;
`endif

endmodule

// File: tb/tb_vram_responder.sv
// Directed bench for vram_responder: host preload, bus read/write, aliasing,
// strobe conflict, host arbitration and reset during a write.
module tb_vram_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        vrd_n = 1'b1;
    logic        vawr_n = 1'b1;
    logic        vbwr_n = 1'b1;
    logic        va14 = 1'b0;
    logic [13:0] vaa = '0;
    logic [13:0] vab = '0;
    logic [7:0]  vda_i = '0;
    logic [7:0]  vdb_i = '0;
    logic [7:0]  vda_o;
    logic [7:0]  vdb_o;
    logic        vd_dir_o;
    logic        host_valid = 1'b0;
    logic        host_ready;
    logic        host_we = 1'b0;
    logic        host_bank = 1'b0;
    logic [9:0]  host_addr = '0;
    logic [7:0]  host_wdata = '0;
    logic [7:0]  host_rdata;
    logic        host_rvalid;
    logic        error_conflict_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    vram_responder dut (
        .clock            (clock),
        .reset            (reset),
        .vrd_n            (vrd_n),
        .vawr_n           (vawr_n),
        .vbwr_n           (vbwr_n),
        .va14             (va14),
        .vaa              (vaa),
        .vab              (vab),
        .vda_i            (vda_i),
        .vdb_i            (vdb_i),
        .vda_o            (vda_o),
        .vdb_o            (vdb_o),
        .vd_dir_o         (vd_dir_o),
        .host_valid       (host_valid),
        .host_ready       (host_ready),
        .host_we          (host_we),
        .host_bank        (host_bank),
        .host_addr        (host_addr),
        .host_wdata       (host_wdata),
        .host_rdata       (host_rdata),
        .host_rvalid      (host_rvalid),
        .error_conflict_o (error_conflict_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic host_xfer(input string tag, input logic we, input logic bank,
                             input logic [9:0] addr, input logic [7:0] wdata, input logic [7:0] exp);
        int n;
        host_valid = 1'b1;
        host_we    = we;
        host_bank  = bank;
        host_addr  = addr;
        host_wdata = wdata;
        n = 0;
        while (!host_ready && n < 64) begin
            tick(1);
            n++;
        end
        if (!host_ready) begin
            check({tag, "_ready_timeout"}, 32'(host_ready), 32'd1);
            host_valid = 1'b0;
            return;
        end
        tick(1);
        host_valid = 1'b0;
        if (!we) begin
            check({tag, "_rvalid"}, 32'(host_rvalid), 32'd1);
            check({tag, "_rdata"}, 32'(host_rdata), 32'(exp));
        end
        $display("host %s bank=%0d addr=%03h wdata=%02h rdata=%02h (%s)",
                 we ? "wr" : "rd", bank, addr, wdata, host_rdata, tag);
        tick(1);
        if (!we) begin
            check({tag, "_rvalid_once"}, 32'(host_rvalid), 32'd0);
        end
    endtask

    initial begin
        int busy_ready;

        // Reset state
        tick(4);
        check("rst_dir", 32'(vd_dir_o), 32'd0);
        check("rst_vda", 32'(vda_o), 32'd0);
        check("rst_vdb", 32'(vdb_o), 32'd0);
        check("rst_ready", 32'(host_ready), 32'd0);
        check("rst_rvalid", 32'(host_rvalid), 32'd0);
        check("rst_rdata", 32'(host_rdata), 32'd0);
        check("rst_err", 32'(error_conflict_o), 32'd0);
        reset = 1'b1;
        tick(3);
        check("idle_ready", 32'(host_ready), 32'd1);

        // Preload
        host_xfer("pre_a005", 1'b1, 1'b0, 10'h005, 8'h3C, 8'h00);
        host_xfer("pre_b005", 1'b1, 1'b1, 10'h005, 8'hC3, 8'h00);
        host_xfer("pre_b123", 1'b1, 1'b1, 10'h123, 8'h11, 8'h00);
        host_xfer("pre_a000", 1'b1, 1'b0, 10'h000, 8'h00, 8'h00);
        host_xfer("pre_b040", 1'b1, 1'b1, 10'h040, 8'h99, 8'h00);
        host_xfer("pre_a0aa", 1'b1, 1'b0, 10'h0AA, 8'h12, 8'h00);

        // Bus read, with a host read held pending across it
        vaa = 14'h0005; vab = 14'h0005; va14 = 1'b0; vrd_n = 1'b0;
        tick(3);
        check("rd_dir_lat3", 32'(vd_dir_o), 32'd0);
        host_valid = 1'b1; host_we = 1'b0; host_bank = 1'b0; host_addr = 10'h005;
        check("rd_ready_busy", 32'(host_ready), 32'd0);
        tick(1);
        check("rd_vda", 32'(vda_o), 32'h3C);
        check("rd_vdb", 32'(vdb_o), 32'hC3);
        check("rd_dir_lat4", 32'(vd_dir_o), 32'd1);
        busy_ready = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (host_ready || host_rvalid) busy_ready++;
        end
        check("rd_hold_ready", 32'(busy_ready), 32'd0);
        check("rd_hold_vda", 32'(vda_o), 32'h3C);
        vrd_n = 1'b1;
        tick(2);
        check("rd_dir_synced_rise", 32'(vd_dir_o), 32'd1);
        tick(1);
        check("rd_dir_release", 32'(vd_dir_o), 32'd0);
        check("rd_vda_release", 32'(vda_o), 32'd0);
        check("rd_vdb_release", 32'(vdb_o), 32'd0);
        check("rd_ready_idle", 32'(host_ready), 32'd1);
        tick(1);
        host_valid = 1'b0;
        check("held_rvalid", 32'(host_rvalid), 32'd1);
        check("held_rdata", 32'(host_rdata), 32'h3C);
        $display("host rd bank=0 addr=005 rdata=%02h (held across bus read)", host_rdata);
        tick(1);
        check("held_once", 32'(host_rvalid), 32'd0);

        // Bus write to bank A only
        vaa = 14'h0123; vab = 14'h0123; vda_i = 8'h5A; vdb_i = 8'hA5; vawr_n = 1'b0;
        tick(5);
        check("wr_dir", 32'(vd_dir_o), 32'd0);
        check("wr_ready", 32'(host_ready), 32'd0);
        tick(5);
        vawr_n = 1'b1;
        host_xfer("wr_a123", 1'b0, 1'b0, 10'h123, 8'h00, 8'h5A);
        host_xfer("wr_b123_keep", 1'b0, 1'b1, 10'h123, 8'h00, 8'h11);

        // Aliasing: {1, 0x0400} truncates to index 0
        va14 = 1'b1; vaa = 14'h0400; vda_i = 8'h77; vawr_n = 1'b0;
        tick(10);
        vawr_n = 1'b1;
        tick(4);
        va14 = 1'b0;
        host_xfer("alias_a000", 1'b0, 1'b0, 10'h000, 8'h00, 8'h77);

        // Conflict: read and bank B write together
        vab = 14'h0040; vdb_i = 8'hEE; vrd_n = 1'b0; vbwr_n = 1'b0;
        tick(2);
        check("conf_pre", 32'(error_conflict_o), 32'd0);
        tick(1);
        check("conf_err", 32'(error_conflict_o), 32'd1);
        tick(5);
        check("conf_dir", 32'(vd_dir_o), 32'd0);
        check("conf_vdb", 32'(vdb_o), 32'd0);
        check("conf_ready", 32'(host_ready), 32'd0);
        vrd_n = 1'b1; vbwr_n = 1'b1;
        host_xfer("conf_b040", 1'b0, 1'b1, 10'h040, 8'h00, 8'h99);
        check("conf_sticky", 32'(error_conflict_o), 32'd1);
        vaa = 14'h0005; vrd_n = 1'b0;
        tick(4);
        check("conf_recover_vda", 32'(vda_o), 32'h3C);
        check("conf_recover_dir", 32'(vd_dir_o), 32'd1);
        vrd_n = 1'b1;
        tick(3);
        check("conf_recover_rel", 32'(vd_dir_o), 32'd0);

        // Reset while a write is held
        vaa = 14'h00AA; vda_i = 8'h34; vawr_n = 1'b0;
        tick(5);
        reset = 1'b0;
        tick(1);
        check("mrst_dir", 32'(vd_dir_o), 32'd0);
        check("mrst_vda", 32'(vda_o), 32'd0);
        check("mrst_vdb", 32'(vdb_o), 32'd0);
        check("mrst_ready", 32'(host_ready), 32'd0);
        check("mrst_rvalid", 32'(host_rvalid), 32'd0);
        check("mrst_err", 32'(error_conflict_o), 32'd0);
        vawr_n = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(2);
        host_xfer("mrst_a0aa", 1'b0, 1'b0, 10'h0AA, 8'h00, 8'h12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vram_responder.md
Name: vram_responder

Overview:
- Emulates the two SNES VRAM chips (bank A on vda/vaa, bank B on vdb/vab) on the VRAM bus.
- An external initiator drives the strobes; this block responds. The initiator is either a PPU, or vram_control on a second board / loopback harness during bringup.
- Two internal block RAMs (one per bank) serve reads and absorb writes.
- A host port lets bringup logic (UART command decoder) preload and inspect the memory.

Parameters:
- ADDR_BITS, 10, per-bank memory depth is 2^ADDR_BITS bytes; bus address truncated to these LSBs (aliasing).
- SYNC_STAGES, 2, flip-flop stages on every asynchronous bus input (min 2).

Ports:
- clock  in  1  system clock (12 MHz)
- reset  in  1  synchronous, active-low
- vrd_n  in  1  bus read strobe, async
- vawr_n  in  1  bank A write strobe, async
- vbwr_n  in  1  bank B write strobe, async
- va14  in  1  shared address bit 14
- vaa  in  14  bank A address
- vab  in  14  bank B address
- vda_i / vdb_i  in  8  bank data from pins
- vda_o / vdb_o  out  8  bank data to pins
- vd_dir_o  out  1  level-shifter direction; LVL_DIR_OUTPUT only while driving read data
- host_valid  in  1  host request
- host_ready  out  1  host request accepted this cycle when valid&&ready
- host_we  in  1  1=write, 0=read
- host_bank  in  1  0=A, 1=B
- host_addr  in  ADDR_BITS  host address
- host_wdata  in  8  host write data
- host_rdata  out  8  host read data
- host_rvalid  out  1  one-cycle pulse; host_rdata valid
- error_conflict_o  out  1  sticky: vrd_n and a write strobe low simultaneously

Behaviour:
- Reset values: vd_dir_o=LVL_DIR_INPUT, vda_o=vdb_o=0, host_ready=0, host_rvalid=0, host_rdata=0, error_conflict_o=0, state=IDLE. Synchronizers reset to 1 (strobes inactive). RAM contents not reset.
- All bus inputs pass through SYNC_STAGES flops. Edges are detected on the synced strobes; a "fall" is synced 1 then 0 on consecutive cycles.
- Address index per bank: {va14, vaX}[ADDR_BITS-1:0], captured on the synchronized strobe fall.
- States:
  - IDLE: accepts host requests; watches strobes.
  - RD_FETCH: one RAM read cycle, both banks.
  - RD_DRIVE: drive data out.
  - WR_HOLD: write strobe active.
- IDLE -> RD_FETCH on vrd_n fall: latch both addresses.
- RD_FETCH -> RD_DRIVE after 1 cycle: vda_o/vdb_o = RAM data, vd_dir_o=OUTPUT.
- Read latency: pin fall to driven data = SYNC_STAGES+2 clocks (4 at default).
- RD_DRIVE -> IDLE when synced vrd_n==1. In that same cycle vd_dir_o returns to INPUT and vda_o/vdb_o return to 0.
- IDLE -> WR_HOLD on vawr_n or vbwr_n fall: latch addresses and per-bank enables. A strobe falling 1 cycle later while in WR_HOLD also sets its enable.
- In WR_HOLD, synced vda_i/vdb_i are captured every cycle while the corresponding strobe is low.
- When both strobes are synced high: commit enabled banks with the last captured data, then -> IDLE. The RAM write occurs in the exit cycle.
- vd_dir_o stays INPUT throughout writes.
- Conflict: vrd_n low together with any write strobe (synced), in any state:
  - set error_conflict_o;
  - abort to IDLE with no RAM write and no drive;
  - stay in IDLE until all three strobes are synced high.
- Only reset clears error_conflict_o.
- Host port:
  - host_ready=1 only in IDLE with all synced strobes high. The bus has strict priority.
  - Accepted write: RAM written in the next cycle.
  - Accepted read: host_rdata valid with host_rvalid=1 exactly 1 cycle after acceptance.
  - Bus fall in the same cycle as host accept: host is not accepted, because ready was computed from the prior synced strobes and is 0.
- Reset mid-operation: outputs return to reset values next clock; any pending write is dropped.

Optional Feature:
- Macro: VRAM_RESPONDER_TRACE_EN.
- Defined:
  - Extra outputs trace_data[23:0] = {op[1:0], va14, bank-A index zero-extended to 13 bits, data[7:0]} and trace_valid.
  - One-cycle pulse per completed bus read (op=01, data=vda_o) and per committed write (op=10 for A, 11 for B; B write uses B index/data). Emitted in the RD_DRIVE entry cycle or the commit cycle.
  - A simultaneous A+B commit emits A, then B on the next cycle.
- Undefined: ports absent, no logic.

Decomposition:
- Shared package: LVL_DIR_INPUT/LVL_DIR_OUTPUT, state encodings, trace op codes.
- Sub-module: vram_responder_bank (one instance per bank). It wraps the dual-use RAM (bus port + host port mux), the write-data capture register and the output data register.

Test Plan:
- Host writes A[0x005]=0x3C and B[0x005]=0xC3, then bus read with vaa=vab=0x0005, vrd_n low 20 clocks -> vda_o=0x3C, vdb_o=0xC3, vd_dir_o=OUTPUT from clock 4 after fall; INPUT 1 clock after synced rise.
- Bus write with vawr_n low 10 clocks, vaa=0x0123, vda_i=0x5A, vbwr_n high -> host read A[0x123]=0x5A with host_rvalid 1 cycle after accept; B[0x123] unchanged.
- Aliasing: bus write with va14=1, vaa=0x0400, data 0x77 (ADDR_BITS=10) -> host read A[0x000]=0x77.
- Conflict: vrd_n and vbwr_n low together -> error_conflict_o=1, no RAM change, vd_dir_o stays INPUT; recovers to normal reads after strobes rise.
- Host request held valid during a bus read -> host_ready=0 until IDLE; accepted exactly once afterwards.
- Reset asserted during WR_HOLD -> no write committed (host read returns prior value); all outputs at reset values.
